// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction handshake and program-load bus between sequencer and its neighbours
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   prog_we;
    logic [ADDR_WIDTH-1:0]  prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;

    modport master (
        output instr_valid, instruction,
        input  instr_ready, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  instr_valid, instruction,
        output instr_ready, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: program RAM plus PC sequencer feeding the control unit; define SEQ_STEP_EN for single-step PAUSE
module instr_sequencer #(
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
`ifdef SEQ_STEP_EN
    input  logic                  step,
`endif
    instr_sequencer_if.master     bus,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, DONE
`ifdef SEQ_STEP_EN
        , PAUSE
`endif
    } state_t;

    state_t                 state, state_n;
    logic [INSTR_WIDTH-1:0] ram [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_reg, instruction_n;
    logic [ADDR_WIDTH-1:0]  pc_n, target;
    logic                   valid_n, overrun_n, loop_active, loop_active_n;
    logic [3:0]             loop_cnt, loop_cnt_n, opcode, count;
    logic                   last, idle;

    assign opcode = instr_reg[INSTR_WIDTH-1 -: 4];
    assign count  = instr_reg[11:8];
    assign target = instr_reg[ADDR_WIDTH-1:0];
    assign last   = pc == ADDR_WIDTH'(DEPTH - 1);
    assign idle   = state == IDLE || state == DONE;
    assign busy   = !idle;
    assign done   = state == DONE;

    // program load only while stopped; word at pc is captured at the end of FETCH
    always_ff @(posedge clock) begin
        if (bus.prog_we && idle) ram[bus.prog_addr] <= bus.prog_data;
        if (state == FETCH) instr_reg <= ram[pc];
    end

    // state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= '0;
            bus.instr_valid <= 1'b0;
            bus.instruction <= '0;
            overrun         <= 1'b0;
            loop_active     <= 1'b0;
            loop_cnt        <= '0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            bus.instr_valid <= valid_n;
            bus.instruction <= instruction_n;
            overrun         <= overrun_n;
            loop_active     <= loop_active_n;
            loop_cnt        <= loop_cnt_n;
        end
    end

    // next state: flow-control words resolve in DECODE, others are issued over the handshake
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        valid_n       = bus.instr_valid;
        instruction_n = bus.instruction;
        overrun_n     = overrun;
        loop_active_n = loop_active;
        loop_cnt_n    = loop_cnt;
        case (state)
            IDLE, DONE: begin
                if (state == IDLE || start) begin
                    loop_active_n = 1'b0;
                    loop_cnt_n    = '0;
                end
                if (start) begin
                    state_n   = FETCH;
                    pc_n      = '0;
                    overrun_n = 1'b0;
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                state_n = FETCH;
                if (opcode == 4'hF) state_n = DONE;
                else if (opcode == 4'hE) pc_n = target;
                else if (opcode == 4'hD) begin
                    if (loop_active ? loop_cnt == 4'd0 : count == 4'd0) begin
                        loop_active_n = 1'b0;
                        if (last) begin
                            state_n   = DONE;
                            overrun_n = 1'b1;
                        end else pc_n = pc + 1'b1;
                    end else begin
                        loop_active_n = 1'b1;
                        loop_cnt_n    = loop_active ? loop_cnt - 4'd1 : count - 4'd1;
                        pc_n          = target;
                    end
                end else begin
                    state_n       = ISSUE;
                    valid_n       = 1'b1;
                    instruction_n = instr_reg;
                end
            end
            ISSUE: if (bus.instr_ready) begin
                valid_n = 1'b0;
                if (last) begin
                    state_n   = DONE;
                    overrun_n = 1'b1;
                end else begin
                    pc_n = pc + 1'b1;
`ifdef SEQ_STEP_EN
                    state_n = PAUSE;
`else
                    state_n = FETCH;
`endif
                end
            end
`ifdef SEQ_STEP_EN
            PAUSE: if (step) state_n = FETCH;
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random programs checked against an instruction-level reference model
module tb_instr_sequencer;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
`ifdef SEQ_STEP_EN
    logic step = 1'b1;
`endif
    logic [5:0] pc;
    logic busy, done, overrun;
    int errors = 0, checks = 0, first_cyc;
    logic [15:0] mem [64];
    logic [15:0] exp_q[$], got_q[$];
    int exp_pc;
    bit exp_over, ok;

    instr_sequencer_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(6)) bus();

    instr_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .bus(bus), .pc(pc), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // executes the RAM image word by word; returns ok=0 if it does not finish within 300 steps
    task automatic model(output bit fin);
        int p = 0, lc = 0;
        bit la = 0;
        logic [15:0] w;
        exp_q.delete();
        exp_over = 0;
        fin = 0;
        for (int s = 0; s < 300; s++) begin
            w = mem[p];
            if (w[15:12] == 4'hF) begin
                exp_pc = p;
                fin = 1;
                return;
            end else if (w[15:12] == 4'hE) p = int'(w[5:0]);
            else begin
                if (w[15:12] == 4'hD && ((la && lc > 0) || (!la && w[11:8] > 0))) begin
                    lc = la ? lc - 1 : int'(w[11:8]) - 1;
                    la = 1;
                    p = int'(w[5:0]);
                end else begin
                    if (w[15:12] == 4'hD) la = 0;
                    else exp_q.push_back(w);
                    if (p == 63) begin
                        exp_pc = 63;
                        exp_over = 1;
                        fin = 1;
                        return;
                    end
                    p++;
                end
            end
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < 64; i++) begin
            bus.prog_we = 1'b1;
            bus.prog_addr = 6'(i);
            bus.prog_data = mem[i];
            @(negedge clock);
        end
        bus.prog_we = 1'b0;
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 64; i++) mem[i] = w;
    endtask

    task automatic gen_prog();
        bit fin = 0;
        int r;
        logic [15:0] w;
        while (!fin) begin
            for (int i = 0; i < 64; i++) begin
                r = $urandom_range(0, 99);
                w = 16'($urandom);
                if (r < 6) w[15:12] = 4'hF;
                else if (r < 12) w[15:12] = 4'hE;
                else if (r < 20) begin
                    w[15:12] = 4'hD;
                    w[11:8] = 4'($urandom_range(0, 3));
                end else w[15:12] = 4'($urandom_range(0, 12));
                mem[i] = w;
            end
            model(fin);
        end
    endtask

    // mode 0: random ready, 1: ready high, 2: ready low for first 5 ISSUE cycles, 3: ready high with busy write and start
    task automatic run(input int mode, input string tag);
        int cyc = 1;
        bit pend = 0;
        logic [15:0] held = '0;
        bit fin;
        model(fin);
        got_q.delete();
        first_cyc = -1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_start"}, {done, overrun, busy}, 3'b001);
        while (!done && cyc < 20000) begin
            bus.instr_ready = mode == 1 || mode == 3 ? 1'b1 : mode == 2 ? cyc > 7 : 1'($urandom_range(0, 1));
            bus.prog_we = mode == 3 && cyc < 5;
            bus.prog_addr = '0;
            bus.prog_data = 16'h5555;
            start = mode == 3 && cyc == 4;
            if (pend) check({tag, "_hold"}, {bus.instr_valid, bus.instruction}, {1'b1, held});
            if (bus.instr_valid && first_cyc < 0) first_cyc = cyc;
            pend = bus.instr_valid && !bus.instr_ready;
            held = bus.instruction;
            if (bus.instr_valid && bus.instr_ready) got_q.push_back(bus.instruction);
            @(negedge clock);
            cyc++;
        end
        bus.prog_we = 1'b0;
        start = 1'b0;
        check({tag, "_finished"}, done, 1'b1);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size()) check({tag, "_word"}, got_q[i], exp_q[i]);
        check({tag, "_overrun"}, overrun, exp_over);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_idle"}, {busy, bus.instr_valid}, 2'b00);
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset", {bus.instr_valid, busy, done, overrun}, 4'b0000);
        check("reset_pc", pc, 6'd0);
        check("reset_instr", bus.instruction, 16'h0000);

        fill(16'hF000);
        mem[0] = 16'h1234; mem[1] = 16'h2567; mem[2] = 16'hF000;
        load_all();
        run(1, "basic");
        check("basic_latency", first_cyc, 3);
        check("basic_n", got_q.size(), 2);
        run(2, "stall");
        check("stall_n", got_q.size(), 2);

        fill(16'hF000);
        mem[0] = 16'h1111; mem[1] = 16'hD200;
        load_all();
        run(0, "loop");
        check("loop_n", got_q.size(), 3);

        fill(16'hF000);
        mem[0] = 16'hE005; mem[5] = 16'h3ABC; mem[6] = 16'hF000;
        load_all();
        run(0, "jmp");
        check("jmp_n", got_q.size(), 1);

        fill(16'h1000);
        load_all();
        run(1, "over1");
        check("over1_n", got_q.size(), 64);
        run(0, "over2");
        check("over2_flag", overrun, 1'b1);

        fill(16'hF000);
        mem[0] = 16'h1234; mem[1] = 16'h7777;
        load_all();
        run(3, "wbusy");
        run(1, "wbusy_again");

        bus.instr_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("mid_valid", bus.instr_valid, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset", {bus.instr_valid, busy, done, overrun}, 4'b0000);
        check("mid_reset_pc", pc, 6'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int t = 0; t < 15; t++) begin
            gen_prog();
            load_all();
            run(0, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
